// File: rtl/pc_fetch_pkg.sv
// Shared constants for the PC/instruction-fetch sequencer.
// State encodings are fixed values so existing waveforms and decoders still match.
package pc_fetch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack port plus the valid/stall handshake towards decode.
// The master modport is the fetch-unit side.
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, stall
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Redirects flush the presented instruction and drain any in-flight request.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    pc_fetch_unit_if.master bus
);

    logic [1:0]  state;
    logic [31:0] req_addr;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic [31:0] npc_aligned;

    assign npc_aligned = npc & ALIGN_MASK;
    assign pc_plus4    = pc + INSTR_BYTES;

    assign bus.imem_req    = (state == REQ) || (state == DRAIN);
    assign bus.imem_addr   = req_addr;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_addr <= pc;
                    state    <= REQ;
                end
                REQ: begin
                    if (bus.imem_ack && !redirect) begin
                        instr_q       <= bus.imem_rdata;
                        instr_pc_q    <= req_addr;
                        instr_valid_q <= 1'b1;
                        state         <= VALID;
                    end else if (bus.imem_ack) begin
                        // Completed request is stale: reissue immediately at the target.
                        pc       <= npc_aligned;
                        req_addr <= npc_aligned;
                    end else if (redirect) begin
                        pc    <= npc_aligned;
                        state <= DRAIN;
                    end
                end
                VALID: begin
                    if (redirect || !bus.stall) begin
                        pc            <= npc_aligned;
                        req_addr      <= npc_aligned;
                        instr_valid_q <= 1'b0;
                        state         <= REQ;
                    end
                end
                default: begin
                    // DRAIN: the old address stays on the bus until its ack arrives.
                    if (redirect) begin
                        pc <= npc_aligned;
                    end
                    if (bus.imem_ack) begin
                        req_addr <= redirect ? npc_aligned : pc;
                        state    <= REQ;
                    end
                end
            endcase
        end
    end

endmodule
